// File: rtl/dff_bank_ctrl.sv
// Shares a bank of preset/clear DFF cells between two round-robin requesters and
// sequences the per-bit d/preset/clear controls to READ, LOAD, SET or CLR masked bits.
module dff_bank_ctrl #(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_mask,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_mask,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    input  logic [WIDTH-1:0] bank_q,
    output logic [WIDTH-1:0] bank_d,
    output logic [WIDTH-1:0] bank_preset,
    output logic [WIDTH-1:0] bank_clear
);

    typedef enum logic [1:0] {IDLE, ACT, SETTLE, RESP} state_t;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;
    localparam logic [3:0] PULSE_LEN = 4'(PULSE_CYCLES);

    state_t           state, state_nxt;
    logic             last_grant, last_grant_nxt;
    logic             grant_id;
    logic [1:0]       cur_op, cur_op_nxt;
    logic [WIDTH-1:0] cur_mask, cur_mask_nxt;
    logic [WIDTH-1:0] cur_data, cur_data_nxt;
    logic             cur_id, cur_id_nxt;
    logic [3:0]       pulse_cnt, pulse_cnt_nxt;
    logic [3:0]       act_len;

    logic             req0_ready_nxt, req1_ready_nxt;
    logic             resp_valid_nxt, resp_id_nxt;
    logic [WIDTH-1:0] resp_data_nxt;
    logic [WIDTH-1:0] bank_d_nxt, bank_preset_nxt, bank_clear_nxt;

    // SET and CLR share op[1]=1 and are the only pulsed operations.
    assign act_len = cur_op[1] ? PULSE_LEN : 4'd1;

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        grant_id        = 1'b0;
        cur_op_nxt      = cur_op;
        cur_mask_nxt    = cur_mask;
        cur_data_nxt    = cur_data;
        cur_id_nxt      = cur_id;
        pulse_cnt_nxt   = pulse_cnt;
        req0_ready_nxt  = 1'b0;
        req1_ready_nxt  = 1'b0;
        resp_valid_nxt  = 1'b0;
        resp_id_nxt     = resp_id;
        resp_data_nxt   = resp_data;
        bank_d_nxt      = bank_q;
        bank_preset_nxt = '1;
        bank_clear_nxt  = '1;

        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) grant_id = ~last_grant;
                    else                          grant_id = req1_valid;
                    last_grant_nxt = grant_id;
                    cur_id_nxt     = grant_id;
                    cur_op_nxt     = grant_id ? req1_op   : req0_op;
                    cur_mask_nxt   = grant_id ? req1_mask : req0_mask;
                    cur_data_nxt   = grant_id ? req1_data : req0_data;
                    req0_ready_nxt = ~grant_id;
                    req1_ready_nxt = grant_id;
                    pulse_cnt_nxt  = '0;
                    state_nxt      = ACT;
                end
            end
            ACT: begin
                case (cur_op)
                    OP_READ: bank_d_nxt      = bank_q;
                    OP_LOAD: bank_d_nxt      = (cur_data & cur_mask) | (bank_q & ~cur_mask);
                    OP_SET:  bank_preset_nxt = ~cur_mask;
                    OP_CLR:  bank_clear_nxt  = ~cur_mask;
                endcase
                if (pulse_cnt == act_len - 4'd1) state_nxt = SETTLE;
                else                             pulse_cnt_nxt = pulse_cnt + 4'd1;
            end
            SETTLE: begin
                // The cells capture the LOAD value on this same edge, so bank_q is one
                // cycle stale here; keep driving the loaded value instead.
                if (cur_op == OP_LOAD) bank_d_nxt = bank_d;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid_nxt = 1'b1;
                resp_id_nxt    = cur_id;
                resp_data_nxt  = bank_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (clear) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cur_op      <= OP_READ;
            cur_mask    <= '0;
            cur_data    <= '0;
            cur_id      <= 1'b0;
            pulse_cnt   <= '0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_data   <= '0;
            bank_d      <= '0;
            bank_preset <= '1;
            bank_clear  <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            cur_op      <= cur_op_nxt;
            cur_mask    <= cur_mask_nxt;
            cur_data    <= cur_data_nxt;
            cur_id      <= cur_id_nxt;
            pulse_cnt   <= pulse_cnt_nxt;
            req0_ready  <= req0_ready_nxt;
            req1_ready  <= req1_ready_nxt;
            resp_valid  <= resp_valid_nxt;
            resp_id     <= resp_id_nxt;
            resp_data   <= resp_data_nxt;
            bank_d      <= bank_d_nxt;
            bank_preset <= bank_preset_nxt;
            bank_clear  <= bank_clear_nxt;
        end
    end

endmodule

// File: tb/tb_dff_bank_ctrl.sv
// Bench for dff_bank_ctrl: behavioural preset/clear cell bank, directed vector table,
// multi-cycle corner sequences and a randomized run against a transaction-level model.
module tb_dff_bank_ctrl;

    localparam int W     = 8;
    localparam int PULSE = 2;

    typedef struct {
        logic         id;
        logic [1:0]   op;
        logic [W-1:0] mask;
        logic [W-1:0] data;
        logic [W-1:0] exp_data;
        int           exp_lat;
    } vec_t;

    logic         clk;
    logic         clear;
    logic         req0_valid, req1_valid;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_mask, req1_mask, req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         resp_valid, resp_id;
    logic [W-1:0] resp_data, bank_q, bank_d, bank_preset, bank_clear;
    logic [W-1:0] cell_st = '1;
    logic [W-1:0] overlap;
    logic         inv_en = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;
    vec_t         vecs [9];

    dff_bank_ctrl #(.WIDTH(W), .PULSE_CYCLES(PULSE)) dut (
        .clk(clk), .clear(clear),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_mask(req0_mask), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_mask(req1_mask), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .bank_q(bank_q), .bank_d(bank_d), .bank_preset(bank_preset), .bank_clear(bank_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell model: async active-low preset wins over clear, otherwise d is captured on clk.
    assign bank_q  = ~bank_preset | (bank_clear & cell_st);
    always @(posedge clk) cell_st <= ~bank_preset | (bank_clear & bank_d);

    assign overlap = ~bank_preset & ~bank_clear;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (inv_en) check("preset_clear_overlap", 32'(overlap), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic id, input logic v, input logic [1:0] op,
                             input logic [W-1:0] mask, input logic [W-1:0] data);
        if (id) begin
            req1_valid = v; req1_op = op; req1_mask = mask; req1_data = data;
        end else begin
            req0_valid = v; req0_op = op; req0_mask = mask; req0_data = data;
        end
    endtask

    task automatic do_reset(input int cycles);
        clear = 1'b1;
        repeat (cycles) tick();
        clear = 1'b0;
    endtask

    // Issues one request and returns the ready-to-response latency (-1 on timeout).
    task automatic run_op(input logic id, input logic [1:0] op, input logic [W-1:0] mask,
                          input logic [W-1:0] data, output int lat, output logic rid,
                          output logic [W-1:0] rdata);
        int n;
        lat   = -1;
        rid   = 1'b0;
        rdata = '0;
        drive_req(id, 1'b1, op, mask, data);
        n = 0;
        tick();
        while (!(id ? req1_ready : req0_ready) && n < 10) begin
            tick();
            n++;
        end
        drive_req(id, 1'b0, 2'b00, '0, '0);
        if (id ? req1_ready : req0_ready) begin
            n = 0;
            while (!resp_valid && n < 20) begin
                tick();
                n++;
            end
            if (resp_valid) begin
                lat   = n;
                rid   = resp_id;
                rdata = resp_data;
            end
        end
    endtask

    function automatic logic [W-1:0] apply_op(input logic [W-1:0] bank, input logic [1:0] op,
                                              input logic [W-1:0] mask, input logic [W-1:0] data);
        case (op)
            2'b00:   return bank;
            2'b01:   return (bank & ~mask) | (data & mask);
            2'b10:   return bank | mask;
            default: return bank & ~mask;
        endcase
    endfunction

    // Transaction-level model: an accepted op finishes P+2 cycles later, the next accept
    // is allowed P+3 cycles later, and ties go to the requester not granted last.
    task automatic random_phase(input int n_cycles);
        logic [W-1:0] model_bank = '0;
        logic         model_last = 1'b1;
        int           cyc = 0;
        int           free_at = 1;
        int           resp_at = -1;
        logic         exp_id = 1'b0;
        logic [W-1:0] exp_data = '0;
        logic         pend [2];
        logic [1:0]   p_op [2];
        logic [W-1:0] p_mask [2];
        logic [W-1:0] p_data [2];
        logic [1:0]   e_rdy;
        logic         e_resp;
        logic         win;
        int           p;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0; p_op[k] = 2'b00; p_mask[k] = '0; p_data[k] = '0;
        end
        repeat (n_cycles) begin
            e_rdy = 2'b00;
            if (cyc + 1 >= free_at && (pend[0] || pend[1])) begin
                win        = (pend[0] && pend[1]) ? ~model_last : pend[1];
                model_last = win;
                e_rdy[win] = 1'b1;
                p          = (p_op[win] == 2'b10 || p_op[win] == 2'b11) ? PULSE : 1;
                resp_at    = cyc + 1 + p + 2;
                free_at    = cyc + 1 + p + 3;
                model_bank = apply_op(model_bank, p_op[win], p_mask[win], p_data[win]);
                exp_id     = win;
                exp_data   = model_bank;
            end
            tick();
            cyc++;
            e_resp = (cyc == resp_at);
            check("rand_ready", 32'({req1_ready, req0_ready}), 32'(e_rdy));
            check("rand_resp_valid", 32'(resp_valid), 32'(e_resp));
            if (e_resp) begin
                check("rand_resp_id", 32'(resp_id), 32'(exp_id));
                check("rand_resp_data", 32'(resp_data), 32'(exp_data));
            end
            for (int k = 0; k < 2; k++) begin
                if (e_rdy[k]) pend[k] = 1'b0;
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k]   = 1'b1;
                    p_op[k]   = 2'($urandom);
                    p_mask[k] = W'($urandom);
                    p_data[k] = W'($urandom);
                end
            end
            drive_req(1'b0, pend[0], p_op[0], p_mask[0], p_data[0]);
            drive_req(1'b1, pend[1], p_op[1], p_mask[1], p_data[1]);
        end
        drive_req(1'b0, 1'b0, 2'b00, '0, '0);
        drive_req(1'b1, 1'b0, 2'b00, '0, '0);
    endtask

    initial begin
        int           lat;
        int           n;
        logic         rid;
        logic [W-1:0] rdata;

        //            id    op     mask   data   exp    lat
        vecs[0] = '{1'b0, 2'b01, 8'hFF, 8'hF0, 8'hF0, 3};
        vecs[1] = '{1'b0, 2'b01, 8'h0F, 8'hA5, 8'hF5, 3};
        vecs[2] = '{1'b1, 2'b11, 8'hFF, 8'h00, 8'h00, 4};
        vecs[3] = '{1'b1, 2'b10, 8'h81, 8'h00, 8'h81, 4};
        vecs[4] = '{1'b1, 2'b11, 8'h01, 8'h00, 8'h80, 4};
        vecs[5] = '{1'b0, 2'b01, 8'hFF, 8'h3C, 8'h3C, 3};
        vecs[6] = '{1'b1, 2'b01, 8'h00, 8'hFF, 8'h3C, 3};
        vecs[7] = '{1'b0, 2'b00, 8'h00, 8'h00, 8'h3C, 3};
        vecs[8] = '{1'b1, 2'b00, 8'hFF, 8'hAA, 8'h3C, 3};

        clear = 1'b1;
        drive_req(1'b0, 1'b0, 2'b00, '0, '0);
        drive_req(1'b1, 1'b0, 2'b00, '0, '0);

        // Reset held 3 cycles over a bank that powered up at 0xFF.
        for (int c = 0; c < 3; c++) begin
            tick();
            inv_en = 1'b1;
            check("rst_bank_q", 32'(bank_q), 32'h00);
            check("rst_bank_clear", 32'(bank_clear), 32'h00);
            check("rst_bank_preset", 32'(bank_preset), 32'hFF);
            check("rst_bank_d", 32'(bank_d), 32'h00);
            check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_id", 32'(resp_id), 32'd0);
            check("rst_resp_data", 32'(resp_data), 32'h00);
        end
        clear = 1'b0;
        tick();
        check("rel_bank_clear", 32'(bank_clear), 32'hFF);
        check("rel_bank_q", 32'(bank_q), 32'h00);
        check("rel_ready", 32'({req1_ready, req0_ready}), 32'd0);
        check("rel_resp_valid", 32'(resp_valid), 32'd0);

        // LOAD / SET / CLR / zero-mask / READ vectors, applied back to back.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].id, vecs[i].op, vecs[i].mask, vecs[i].data, lat, rid, rdata);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_resp_id", i), 32'(rid), 32'(vecs[i].id));
            check($sformatf("vec%0d_resp_data", i), 32'(rdata), 32'(vecs[i].exp_data));
        end

        // Tie arbitration: both requesters valid continuously from reset release.
        do_reset(2);
        drive_req(1'b0, 1'b1, 2'b00, '0, '0);
        drive_req(1'b1, 1'b1, 2'b00, '0, '0);
        for (int g = 0; g < 4; g++) begin
            n = 0;
            tick();
            while (!req0_ready && !req1_ready && n < 10) begin
                tick();
                n++;
            end
            check($sformatf("tie_grant%0d", g), 32'({req1_ready, req0_ready}),
                  (g % 2 == 0) ? 32'd1 : 32'd2);
            n = 0;
            while (!resp_valid && n < 20) begin
                tick();
                n++;
            end
            check($sformatf("tie_resp_valid%0d", g), 32'(resp_valid), 32'd1);
            check($sformatf("tie_resp_id%0d", g), 32'(resp_id), 32'(g % 2));
        end
        drive_req(1'b0, 1'b0, 2'b00, '0, '0);
        drive_req(1'b1, 1'b0, 2'b00, '0, '0);

        // Abort: reset arrives during the second ACT cycle of a SET.
        do_reset(2);
        drive_req(1'b1, 1'b1, 2'b10, 8'hFF, '0);
        n = 0;
        tick();
        while (!req1_ready && n < 10) begin
            tick();
            n++;
        end
        check("abort_accept", 32'(req1_ready), 32'd1);
        drive_req(1'b1, 1'b0, 2'b00, '0, '0);
        tick();
        check("abort_act1_preset", 32'(bank_preset), 32'h00);
        check("abort_act1_bank_q", 32'(bank_q), 32'hFF);
        tick();
        clear = 1'b1;
        tick();
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_bank_q", 32'(bank_q), 32'h00);
        check("abort_bank_clear", 32'(bank_clear), 32'h00);
        clear = 1'b0;
        drive_req(1'b0, 1'b1, 2'b00, '0, '0);
        tick();
        check("abort_accept_after_release", 32'(req0_ready), 32'd1);
        check("abort_release_bank_clear", 32'(bank_clear), 32'hFF);
        drive_req(1'b0, 1'b0, 2'b00, '0, '0);
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        check("abort_next_latency", 32'(n), 32'd3);
        check("abort_next_resp_id", 32'(resp_id), 32'd0);
        check("abort_next_resp_data", 32'(resp_data), 32'h00);

        // Randomized traffic from a fresh reset.
        do_reset(2);
        random_phase(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
